// File: rtl/mersenne_pkg.sv
// Shared types and constants for the Lucas-Lehmer sequencer
// and its Mersenne reduction datapath.
package mersenne_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SQUARE = 3'd1,
    ST_FOLD   = 3'd2,
    ST_SUB2   = 3'd3,
    ST_FINISH = 3'd4
  } ll_state_e;

  localparam int unsigned LL_SEED = 4;

  function automatic logic [63:0] mersenne_mask(
    input int unsigned p
  );
    return (64'd1 << p) - 64'd1;
  endfunction

endpackage

// File: rtl/lucas_lehmer_sequencer_if.sv
// Host-side start/abort/done handshake and result bus
// of the Lucas-Lehmer sequencer.
interface lucas_lehmer_sequencer_if #(
  parameter int unsigned P = 13
);

  logic         start;
  logic         abort;
  logic         busy;
  logic         done;
  logic         is_prime;
  logic [P-1:0] residue;

  modport master (
    output start,
    output abort,
    input  busy,
    input  done,
    input  is_prime,
    input  residue
  );

  modport slave (
    input  start,
    input  abort,
    output busy,
    output done,
    output is_prime,
    output residue
  );

endinterface

// File: rtl/mersenne_fold.sv
// Combinational reduction of a 2P-bit product modulo 2^P-1,
// returning the canonical residue in [0, 2^P-2].
module mersenne_fold
  import mersenne_pkg::*;
#(
  parameter int unsigned P = 13
) (
  input  logic [2*P-1:0] i_acc,
  output logic [P-1:0]   o_r
);

  localparam logic [P-1:0] MASK = P'(mersenne_mask(P));

  logic [P:0]   w_a;
  logic [P-1:0] w_b;

  // Second fold absorbs the end-around carry; b never exceeds M_P.
  always_comb begin
    w_a = {1'b0, i_acc[P-1:0]} + {1'b0, i_acc[2*P-1:P]};
    w_b = w_a[P-1:0] + P'(w_a[P]);
    o_r = (w_b == MASK) ? '0 : w_b;
  end

endmodule

// File: rtl/lucas_lehmer_sequencer.sv
// Lucas-Lehmer test controller: bit-serial squaring, Mersenne
// fold and subtract-two, repeated P-2 times from the seed.
module lucas_lehmer_sequencer
  import mersenne_pkg::*;
#(
  parameter int unsigned P = 13
) (
  input logic                     clk,
  input logic                     rst,
  lucas_lehmer_sequencer_if.slave bus
);

  if (P < 3 || P > 31) begin : g_bad_p
    $error("lucas_lehmer_sequencer: P must be in 3..31");
  end

  localparam logic [P-1:0] MASK    = P'(mersenne_mask(P));
  localparam logic [P-1:0] SEED    = P'(LL_SEED);
  localparam logic [P-1:0] TWO     = P'(2);
  localparam logic [P-1:0] MASK_M2 = MASK - TWO;
  localparam logic [4:0]   LAST_BIT  = 5'(P - 1);
  localparam logic [4:0]   LAST_ITER = 5'(P - 3);

  ll_state_e r_state;
  ll_state_e w_next;

  logic [P-1:0]   r_s;
  logic [P-1:0]   r_r;
  logic [2*P-1:0] r_acc;
  logic [4:0]     r_bitcnt;
  logic [4:0]     r_iter;

  logic           r_done;
  logic           r_is_prime;
  logic [P-1:0]   r_residue;

  logic           w_busy;
  logic           w_load;
  logic           w_run;
  logic           w_finish;
  logic [P-1:0]   w_sh;
  logic [2*P-1:0] w_pp;
  logic [P-1:0]   w_fold;

  mersenne_fold #(
    .P (P)
  ) u_fold (
    .i_acc (r_acc),
    .o_r   (w_fold)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // abort outranks every transition once a test is running
  always_comb begin
    w_next = r_state;
    if (r_state != ST_IDLE && bus.abort) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) w_next = ST_SQUARE;
        end
        ST_SQUARE: begin
          if (r_bitcnt == LAST_BIT) w_next = ST_FOLD;
        end
        ST_FOLD: begin
          w_next = ST_SUB2;
        end
        ST_SUB2: begin
          w_next = (r_iter == LAST_ITER) ? ST_FINISH
                                         : ST_SQUARE;
        end
        ST_FINISH: begin
          w_next = ST_IDLE;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_busy   = (r_state != ST_IDLE);
    w_load   = (r_state == ST_IDLE) && bus.start;
    w_run    = w_busy && !bus.abort;
    w_finish = (r_state == ST_FINISH) && !bus.abort;
  end

  always_comb begin
    w_sh = r_s >> r_bitcnt;
    w_pp = {{P{1'b0}}, r_s} << r_bitcnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s      <= '0;
      r_r      <= '0;
      r_acc    <= '0;
      r_bitcnt <= '0;
      r_iter   <= '0;
    end else if (w_load) begin
      r_s      <= SEED;
      r_acc    <= '0;
      r_bitcnt <= '0;
      r_iter   <= '0;
    end else if (w_run) begin
      unique case (r_state)
        ST_SQUARE: begin
          if (w_sh[0]) r_acc <= r_acc + w_pp;
          r_bitcnt <= r_bitcnt + 5'd1;
        end
        ST_FOLD: begin
          r_r <= w_fold;
        end
        ST_SUB2: begin
          r_s      <= (r_r >= TWO) ? r_r - TWO
                                   : r_r + MASK_M2;
          r_iter   <= r_iter + 5'd1;
          r_acc    <= '0;
          r_bitcnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done     <= 1'b0;
      r_is_prime <= 1'b0;
      r_residue  <= '0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_residue  <= r_s;
        r_is_prime <= (r_s == '0);
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.is_prime = r_is_prime;
  assign bus.residue  = r_residue;

endmodule

// File: doc/lucas_lehmer_sequencer.md
# lucas_lehmer_sequencer

Sequences a full Lucas–Lehmer primality test for M_P = 2^P − 1 on shared Mersenne-reduction hardware. It iterates s ← (s² − 2) mod M_P, P − 2 times from s = 4, using a bit-serial squarer and a combinational Mersenne fold. It reports the final residue and a prime flag. It sits above the Mersenne reduction datapath as its controller, driven by a start/done handshake from the host logic.

## Interface
- P, 13: Mersenne exponent. Legal range 3..31; out-of-range fails elaboration.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a test; sampled only in IDLE.
- abort  in  1  cancel a running test; sampled in all non-IDLE states.
- busy  out  1  high whenever state ≠ IDLE; derived from the state register.
- done  out  1  one-cycle pulse when residue and is_prime become valid.
- is_prime  out  1  1 iff final residue == 0; held until the next done.
- residue  out  P  final s, canonical in [0, M_P − 1]; held until the next done.

## Operation
- States: IDLE, SQUARE, FOLD, SUB2, FINISH.
- IDLE, start=1: load s←4, acc←0, bitcnt←0, iter←0; go to SQUARE. start=0: stay.
- SQUARE: one multiplier bit per cycle. If s[bitcnt], acc += s << bitcnt.
  - acc is 2P bits wide and never overflows.
  - After bitcnt = P−1, go to FOLD.
- FOLD: r ← fold(acc); go to SUB2. fold is defined as:
  - a = acc[P−1:0] + acc[2P−1:P], P+1 bits.
  - b = a[P−1:0] + a[P], so b ≤ M_P.
  - r = (b == M_P) ? 0 : b.
- SUB2: s ← (r ≥ 2) ? r − 2 : r + M_P − 2. Then iter++, acc←0, bitcnt←0.
  - If iter == P−3 before the increment (the last iteration): go to FINISH.
  - Otherwise: go to SQUARE.
- FINISH: residue←s, is_prime←(s==0), done←1; go to IDLE.
- start while busy: ignored; no queueing.
- abort in any non-IDLE state: go to IDLE at the next edge.
  - No done pulse. residue and is_prime keep their previous values.
  - abort has priority over every other transition.
- start and abort both high in IDLE: start wins; abort is ignored in IDLE.
- rst: state←IDLE; busy=0, done=0, is_prime=0, residue=0; internal s, acc, iter, bitcnt cleared.
  - rst mid-test discards the test silently.

## Timing
- Edge 0 samples start. SQUARE occupies cycles 1..P, FOLD is cycle P+1, SUB2 is cycle P+2.
- Each iteration takes exactly P+2 cycles. N = P−2 iterations.
- FINISH runs in cycle N(P+2)+1. done is high in cycle N(P+2)+2, and busy is low in that same cycle.
  - P=3: done at cycle 7.
  - P=11: done at cycle 119.
  - P=13: done at cycle 167.
- A new start is accepted in the same cycle done is high (state is already IDLE).
- done is never high for two consecutive cycles.

## Structure
- Shared package mersenne_pkg holds:
  - state encodings (IDLE=0, SQUARE=1, FOLD=2, SUB2=3, FINISH=4; 3 bits);
  - constant LL_SEED=4;
  - function mersenne_mask(P) returning 2^P − 1.
- One sub-module: mersenne_fold, purely combinational. Parameter P; input 2P bits; output P bits, canonical.
  - Instantiated once and used only in FOLD.
- Sequencer: FSM, bit-serial squarer, SUB2 logic, output registers. Iteration counter is 5 bits; bit counter is 5 bits.

## Test plan
- P=3 instance: reset, then start pulse -> done at cycle 7; residue=0, is_prime=1; busy high cycles 1..6.
- P=5 instance: start -> intermediate s 14, 8, 0; done at cycle 23 (3·7+2); is_prime=1.
- P=11 instance: start -> done at cycle 119; residue=1736, is_prime=0.
- P=13 instance: start -> done at cycle 167; residue=0, is_prime=1.
  - Then issue a second start in the done cycle -> second done at cycle 167 + 167, same result.
- P=13: abort at cycle 50 -> busy low at cycle 51; no done; residue and is_prime unchanged.
  - Also: start pulses at cycles 10..20 while busy are ignored; done still at 167.
- P=13: rst asserted at cycle 80 for one cycle -> all outputs 0 next cycle.
  - A subsequent start completes normally 167 cycles later.
  - mersenne_fold standalone: inputs M_P, 2·M_P, (2^P−1)², 2^(2P)−1 -> 0, 0, 0, 0. Input M_P+5 -> 5.
